cte_rgb2yuv_gen: RTL and testbench

CTE_RGB2YUV_GEN -- requirements
Module: cte_rgb2yuv_gen

---
 rtl/cte_rgb2yuv_gen.sv | 255 +++++++++++++++++++++++++
 tb/tb_cte_rgb2yuv_gen.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cte_rgb2yuv_gen.sv
// cte_rgb2yuv_gen: RGB to YUV colour-space converter with 4:4:4 / 4:2:2
// serialised output.
//
// Pixels are converted in one registered stage, land in a small FIFO one
// edge later, and a serializer FSM emits one component per cycle:
//   4:4:4 : U, Y, V per pixel
//   4:2:2 : U(avg), Y0, V(avg), Y1 per pixel pair
// A flush pulse drains an unpaired trailing pixel in 4:2:2 mode as U, Y, V.
//
// Ports:
//   clk         - clock, rising edge
//   reset       - synchronous active-high reset
//   sub422      - output format request (1 = 4:2:2, 0 = 4:4:4)
//   in_en       - rgb_in carries a pixel this cycle
//   rgb_in      - {R, G, B}, each DW bits unsigned
//   flush       - single-cycle pulse, drains an unpaired 4:2:2 pixel
//   busy        - pixel will not be accepted this cycle
//   out_valid   - yuv_out / out_chan valid
//   yuv_out     - component value (Y unsigned, U/V two's complement)
//   out_chan    - component tag: 0 = Y, 1 = U, 2 = V
//   dbg_state_o - serializer state (0 IDLE, 1 C0, 2 C1, 3 C2, 4 C3)
//
// Input handshake: a pixel is transferred on a rising edge where
// in_en=1 and busy=0; busy depends on registered state only, so it is
// stable for the whole cycle. With busy=1 the pixel is ignored.
module cte_rgb2yuv_gen #(
    parameter int DW    = 8,
    parameter int FRAC  = 8,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sub422,
    input  logic              in_en,
    input  logic [3*DW-1:0]   rgb_in,
    input  logic              flush,
    output logic              busy,
    output logic              out_valid,
    output logic [DW-1:0]     yuv_out,
    output logic [1:0]        out_chan,
    output logic [2:0]        dbg_state_o
);

    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = DW + FRAC + 4;

    // round(c * 2^FRAC) for a coefficient given in thousandths.
    function automatic int coef(input int milli);
        int mag;
        mag = (milli < 0) ? -milli : milli;
        mag = (mag * (1 << FRAC) + 500) / 1000;
        return (milli < 0) ? -mag : mag;
    endfunction

    localparam logic signed [SW-1:0] K_YR = SW'(coef(299));
    localparam logic signed [SW-1:0] K_YG = SW'(coef(587));
    localparam logic signed [SW-1:0] K_YB = SW'(coef(114));
    localparam logic signed [SW-1:0] K_UR = SW'(coef(-169));
    localparam logic signed [SW-1:0] K_UG = SW'(coef(-331));
    localparam logic signed [SW-1:0] K_UB = SW'(coef(500));
    localparam logic signed [SW-1:0] K_VR = SW'(coef(500));
    localparam logic signed [SW-1:0] K_VG = SW'(coef(-419));
    localparam logic signed [SW-1:0] K_VB = SW'(coef(-81));
    localparam logic signed [SW-1:0] RND   = SW'(1 << (FRAC - 1));
    localparam logic signed [SW-1:0] Y_MAX = SW'((1 << DW) - 1);
    localparam logic signed [SW-1:0] S_MAX = SW'((1 << (DW - 1)) - 1);
    localparam logic signed [SW-1:0] S_MIN = ~S_MAX;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_C0   = 3'd1,
        S_C1   = 3'd2,
        S_C2   = 3'd3,
        S_C3   = 3'd4
    } state_t;

    function automatic logic [DW-1:0] sat_u(input logic signed [SW-1:0] x);
        if (x < 0)          return '0;
        else if (x > Y_MAX) return '1;
        else                return x[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] sat_s(input logic signed [SW-1:0] x);
        if (x < S_MIN)      return S_MIN[DW-1:0];
        else if (x > S_MAX) return S_MAX[DW-1:0];
        else                return x[DW-1:0];
    endfunction

    // ---------------- conversion stage ----------------
    logic signed [SW-1:0] r_s, g_s, b_s, sum_y, sum_u, sum_v;
    logic                 accept;
    logic                 conv_vld_q;
    logic [3*DW-1:0]      conv_q;

    assign r_s = $signed({{(SW-DW){1'b0}}, rgb_in[3*DW-1:2*DW]});
    assign g_s = $signed({{(SW-DW){1'b0}}, rgb_in[2*DW-1:DW]});
    assign b_s = $signed({{(SW-DW){1'b0}}, rgb_in[DW-1:0]});

    assign sum_y = (K_YR * r_s + K_YG * g_s + K_YB * b_s + RND) >>> FRAC;
    assign sum_u = (K_UR * r_s + K_UG * g_s + K_UB * b_s + RND) >>> FRAC;
    assign sum_v = (K_VR * r_s + K_VG * g_s + K_VB * b_s + RND) >>> FRAC;

    assign accept = in_en && !busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            conv_vld_q <= 1'b0;
            conv_q     <= '0;
        end else begin
            conv_vld_q <= accept;
            if (accept) conv_q <= {sat_u(sum_y), sat_s(sum_u), sat_s(sum_v)};
        end
    end

    // ---------------- FIFO of converted pixels {Y, U, V} ----------------
    logic [3*DW-1:0] mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d, pop_ext, rem, need;
    logic [1:0]      pop_n;
    state_t          state_q;
    logic            pair_q, mode_q, flush_pend_q;

    // Entries leave on the last component of a group: one for a single
    // pixel group (C2), two for a 4:2:2 pair (C3).
    always_comb begin
        pop_n = 2'd0;
        if (state_q == S_C2 && !pair_q) pop_n = 2'd1;
        if (state_q == S_C3)            pop_n = 2'd2;
    end

    assign pop_ext = {{(CW-2){1'b0}}, pop_n};
    assign count_d = count_q + {{(CW-1){1'b0}}, conv_vld_q} - pop_ext;
    assign rem     = count_q - pop_ext;
    assign need    = mode_q ? CW'(2) : CW'(1);

    // The in-flight pixel always has a slot: busy looks one write ahead.
    assign busy = (count_q == CW'(DEPTH)) ||
                  ((count_q == CW'(DEPTH - 1)) && conv_vld_q);

    always_ff @(posedge clk) begin
        if (conv_vld_q) mem_q[wr_ptr_q] <= conv_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (conv_vld_q) wr_ptr_q <= wr_ptr_q + AW'(1);
            rd_ptr_q <= rd_ptr_q + AW'(pop_n);
            count_q  <= count_d;
        end
    end

    // ---------------- serializer FSM ----------------
    logic unpaired, single_active;

    // Odd number of pixels held (FIFO plus in-flight) means a trailing one.
    assign unpaired      = count_q[0] ^ conv_vld_q;
    assign single_active = (state_q != S_IDLE) && !pair_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pair_q       <= 1'b0;
            flush_pend_q <= 1'b0;
            mode_q       <= sub422;
        end else begin
            // Mode only changes with nothing queued, converting or emitting.
            if (state_q == S_IDLE && count_q == '0 && !conv_vld_q)
                mode_q <= sub422;
            if (flush && mode_q && unpaired && !single_active)
                flush_pend_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (count_q >= need) begin
                        state_q <= S_C0;
                        pair_q  <= mode_q;
                    end else if (mode_q && flush_pend_q &&
                                 count_q == CW'(1) && !conv_vld_q) begin
                        state_q      <= S_C0;
                        pair_q       <= 1'b0;
                        flush_pend_q <= 1'b0;
                    end
                end
                S_C0: state_q <= S_C1;
                S_C1: state_q <= S_C2;
                S_C2: begin
                    if (pair_q) begin
                        state_q <= S_C3;
                    end else if (rem >= need) begin
                        state_q <= S_C0;
                        pair_q  <= mode_q;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_C3: begin
                    if (rem >= need) begin
                        state_q <= S_C0;
                        pair_q  <= mode_q;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dbg_state_o = state_q;

    // ---------------- output mux ----------------
    logic [3*DW-1:0] h0, h1;
    logic [DW:0]     u_sum, v_sum;

    assign h0 = mem_q[rd_ptr_q];
    assign h1 = mem_q[rd_ptr_q + AW'(1)];

    // Sign-extend to DW+1, add with rounding, arithmetic shift by one.
    assign u_sum = {h0[2*DW-1], h0[2*DW-1:DW]} + {h1[2*DW-1], h1[2*DW-1:DW]} + 1'b1;
    assign v_sum = {h0[DW-1], h0[DW-1:0]} + {h1[DW-1], h1[DW-1:0]} + 1'b1;

    always_comb begin
        out_valid = 1'b0;
        out_chan  = 2'd0;
        yuv_out   = '0;
        case (state_q)
            S_C0: begin
                out_valid = 1'b1;
                out_chan  = 2'd1;
                yuv_out   = pair_q ? u_sum[DW:1] : h0[2*DW-1:DW];
            end
            S_C1: begin
                out_valid = 1'b1;
                out_chan  = 2'd0;
                yuv_out   = h0[3*DW-1:2*DW];
            end
            S_C2: begin
                out_valid = 1'b1;
                out_chan  = 2'd2;
                yuv_out   = pair_q ? v_sum[DW:1] : h0[DW-1:0];
            end
            S_C3: begin
                out_valid = 1'b1;
                out_chan  = 2'd0;
                yuv_out   = h1[3*DW-1:2*DW];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cte_rgb2yuv_gen.sv
// Testbench for cte_rgb2yuv_gen: directed steps plus randomised pixel
// streams, checked against a plain-arithmetic reference model that builds
// the expected component stream as {chan, value} entries.
module tb_cte_rgb2yuv_gen;

    logic        clk = 1'b0;
    logic        reset, sub422, in_en, flush;
    logic [23:0] rgb_in;
    logic        busy, out_valid;
    logic [7:0]  yuv_out;
    logic [1:0]  out_chan;
    logic [2:0]  dbg_state;

    cte_rgb2yuv_gen #(.DW(8), .FRAC(8), .DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .sub422      (sub422),
        .in_en       (in_en),
        .rgb_in      (rgb_in),
        .flush       (flush),
        .busy        (busy),
        .out_valid   (out_valid),
        .yuv_out     (yuv_out),
        .out_chan    (out_chan),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_fail   = 0;
    logic [9:0] exp_q[$];
    int         model_mode = 0;
    bit         has_pend   = 0;
    int         pend_y, pend_u, pend_v;
    bit         mon_en = 0;
    int         cur_run = 0, max_run = 0, n_valid = 0, busy_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int clamp(input int x, input int lo, input int hi);
        return (x < lo) ? lo : (x > hi) ? hi : x;
    endfunction

    task automatic model_conv(input logic [23:0] p, output int y, output int u, output int v);
        int r, g, b;
        r = int'(p[23:16]);
        g = int'(p[15:8]);
        b = int'(p[7:0]);
        y = clamp((77 * r + 150 * g + 29 * b + 128) >>> 8, 0, 255);
        u = clamp((-43 * r - 85 * g + 128 * b + 128) >>> 8, -128, 127);
        v = clamp((128 * r - 107 * g - 21 * b + 128) >>> 8, -128, 127);
    endtask

    task automatic push(input int chan, input int val);
        exp_q.push_back({2'(chan), 8'(val)});
    endtask

    task automatic model_accept(input logic [23:0] p);
        int y, u, v;
        model_conv(p, y, u, v);
        if (model_mode == 0) begin
            push(1, u); push(0, y); push(2, v);
        end else if (!has_pend) begin
            pend_y = y; pend_u = u; pend_v = v;
            has_pend = 1;
        end else begin
            push(1, (pend_u + u + 1) >>> 1);
            push(0, pend_y);
            push(2, (pend_v + v + 1) >>> 1);
            push(0, y);
            has_pend = 0;
        end
    endtask

    task automatic model_flush();
        if (model_mode == 1 && has_pend) begin
            push(1, pend_u); push(0, pend_y); push(2, pend_v);
            has_pend = 0;
        end
    endtask

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid === 1'b1) begin
                n_valid++;
                cur_run++;
                if (cur_run > max_run) max_run = cur_run;
                if (exp_q.size() == 0) chk("unexpected_out", 32'(out_valid), 0);
                else chk("out_comp", {22'd0, out_chan, yuv_out}, {22'd0, exp_q.pop_front()});
            end else begin
                cur_run = 0;
                chk("idle_zero", {22'd0, out_chan, yuv_out}, 0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        in_en = 1'b0;
        flush = 1'b0;
        repeat (n) tick();
    endtask

    // Holds in_en high until the pixel is taken; leaves in_en high on return.
    task automatic drive_pixel(input logic [23:0] p);
        in_en  = 1'b1;
        rgb_in = p;
        for (int k = 0; k < 200; k++) begin
            if (busy === 1'b0) begin
                tick();
                model_accept(p);
                return;
            end
            busy_seen++;
            tick();
        end
        chk("accept_timeout", 32'(busy), 0);
    endtask

    task automatic pulse_flush();
        in_en = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        model_flush();
    endtask

    task automatic drain();
        int k;
        k = 0;
        in_en = 1'b0;
        while (exp_q.size() != 0 && k < 500) begin
            tick();
            k++;
        end
        idle(4);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic set_mode(input bit m);
        sub422 = m;
        idle(4);
        model_mode = m;
        has_pend = 0;
    endtask

    task automatic clear_stats();
        n_valid = 0;
        max_run = 0;
        busy_seen = 0;
    endtask

    task automatic expect_comp(input string tag, input int chan, input int val);
        chk({tag, "_valid"}, 32'(out_valid), 1);
        chk({tag, "_chan"}, 32'(out_chan), 32'(chan));
        chk({tag, "_data"}, 32'(yuv_out), 32'(val));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        int k;
        reset = 1'b1; sub422 = 1'b0; in_en = 1'b0; flush = 1'b0; rgb_in = '0;
        repeat (2) tick();
        reset = 1'b0;
        mon_en = 1'b1;
        model_mode = 0;

        // Reset state
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_out", {22'd0, out_chan, yuv_out}, 0);
        chk("rst_state", 32'(dbg_state), 0);

        // 4:4:4 pure red, exact two-cycle latency
        drive_pixel(24'hFF0000);
        in_en = 1'b0;
        chk("lat444_n0", 32'(out_valid), 0);
        tick();
        chk("lat444_n1", 32'(out_valid), 0);
        tick();
        expect_comp("red_u", 1, 8'hD5);
        tick();
        expect_comp("red_y", 0, 8'h4D);
        tick();
        expect_comp("red_v", 2, 8'h7F);
        drain();

        // 4:2:2 white then black, latency measured from the second pixel
        set_mode(1);
        clear_stats();
        drive_pixel(24'hFFFFFF);
        drive_pixel(24'h000000);
        in_en = 1'b0;
        chk("lat422_n0", 32'(out_valid), 0);
        tick();
        chk("lat422_n1", 32'(out_valid), 0);
        tick();
        expect_comp("wb_u", 1, 8'h00);
        tick();
        expect_comp("wb_y0", 0, 8'hFF);
        tick();
        expect_comp("wb_v", 2, 8'h00);
        tick();
        expect_comp("wb_y1", 0, 8'h00);
        drain();
        chk("wb_run", max_run, 4);
        chk("wb_count", n_valid, 4);

        // 4:2:2 three pixels then flush
        clear_stats();
        for (int i = 0; i < 3; i++) drive_pixel(24'($urandom));
        pulse_flush();
        drain();
        chk("flush3_count", n_valid, 7);
        chk("flush3_state", 32'(dbg_state), 0);

        // Flush with an even pixel count does nothing extra
        clear_stats();
        for (int i = 0; i < 2; i++) drive_pixel(24'($urandom));
        pulse_flush();
        drain();
        chk("flush_even_count", n_valid, 4);

        // 4:4:4 flush is ignored
        set_mode(0);
        clear_stats();
        pulse_flush();
        idle(6);
        drive_pixel(24'($urandom));
        pulse_flush();
        drain();
        chk("flush444_count", n_valid, 3);

        // 4:4:4 back-pressured stream of 20 pixels
        clear_stats();
        for (int i = 0; i < 20; i++) drive_pixel(24'($urandom));
        drain();
        chk("stream_run", max_run, 60);
        chk("stream_count", n_valid, 60);
        chk("stream_busy_seen", 32'(busy_seen != 0), 1);

        // Reset while the C1 component is on the output
        drive_pixel(24'($urandom));
        in_en = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (!(out_valid === 1'b1 && out_chan == 2'd0) && k < 50);
        chk("rst_mid_found", 32'(out_valid === 1'b1 && out_chan == 2'd0), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        has_pend = 0;
        model_mode = 0;
        chk("rst_mid_valid", 32'(out_valid), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_state", 32'(dbg_state), 0);
        idle(8);

        // Mode request toggled mid-group: queued pixels stay 4:4:4
        clear_stats();
        drive_pixel(24'($urandom));
        drive_pixel(24'($urandom));
        in_en = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (out_valid !== 1'b1 && k < 50);
        chk("mode_sw_found", 32'(out_valid), 1);
        sub422 = 1'b1;
        tick();
        drain();
        chk("mode_sw_old_count", n_valid, 6);
        model_mode = 1;
        clear_stats();
        drive_pixel(24'($urandom));
        drive_pixel(24'($urandom));
        drain();
        chk("mode_sw_new_count", n_valid, 4);

        // Randomised 4:2:2 traffic with occasional flushes
        for (int i = 0; i < 24; i++) begin
            drive_pixel(24'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                pulse_flush();
                idle(12);
            end else begin
                idle($urandom_range(0, 2));
            end
        end
        pulse_flush();
        drain();

        // Randomised 4:4:4 traffic
        set_mode(0);
        for (int i = 0; i < 24; i++) begin
            drive_pixel(24'($urandom));
            idle($urandom_range(0, 2));
        end
        drain();

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
